// File: rtl/qam_demapper_scheduler_if.sv
// Scheduler <-> FIFO/demapper signal bundle for the two-channel QAM demapper scheduler.
interface qam_demapper_scheduler_if #(
    parameter int unsigned CNT_W = 4
);
    logic             enable;
    logic             rdempty0;
    logic             rdempty1;
    logic             wfull;
    logic             rd_en0;
    logic             rd_en1;
    logic             sel;
    logic             sym_valid;
    logic             available;
    logic             complete;
    logic [CNT_W-1:0] burst_cnt;
    logic [1:0]       state;

    // Scheduler side
    modport master (
        input  enable, rdempty0, rdempty1, wfull,
        output rd_en0, rd_en1, sel, sym_valid, available, complete, burst_cnt, state
    );

    // Controller / FIFO side
    modport slave (
        output enable, rdempty0, rdempty1, wfull,
        input  rd_en0, rd_en1, sel, sym_valid, available, complete, burst_cnt, state
    );
endinterface

// File: rtl/qam_demapper_scheduler.sv
// Round-robin burst scheduler sharing one QAM demapper between two symbol FIFOs.
// Grants a channel, reads up to BURST symbols, then waits PIPE_LAT+1 cycles for
// the demapper pipeline to drain before the next grant.
module qam_demapper_scheduler #(
    parameter int unsigned BURST    = 8,
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                      dclk,
    input  logic                      reset,
    qam_demapper_scheduler_if.master  bus
);
    localparam int unsigned DRN_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GRANT = 2'b01,
        S_BURST = 2'b10,
        S_DRAIN = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic               sel_q, sel_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic               complete_q, complete_d;
    logic               sym_valid_q, sym_valid_d;

    logic               sel_empty;
    logic               grant_ok;
    logic               rd_go;
    logic [CNT_W-1:0]   cnt_inc;

    // Next-state, counters and read strobe decode
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        drain_cnt_d = drain_cnt_q;

        sel_empty = sel_q ? bus.rdempty1 : bus.rdempty0;
        grant_ok  = bus.enable && !bus.wfull && (!bus.rdempty0 || !bus.rdempty1);
        rd_go     = (state_q == S_BURST) && !sel_empty && !bus.wfull
                    && (burst_cnt_q < CNT_W'(BURST)) && !reset;
        cnt_inc   = burst_cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (grant_ok) begin
                    state_d     = S_GRANT;
                    // Single non-empty channel wins; a tie goes to the channel not served last.
                    sel_d       = (bus.rdempty0 || bus.rdempty1) ? bus.rdempty0 : !last_q;
                    burst_cnt_d = '0;
                end
            end
            S_GRANT: begin
                state_d = S_BURST;
            end
            S_BURST: begin
                if (rd_go) begin
                    burst_cnt_d = cnt_inc;
                end
                if ((rd_go && (cnt_inc == CNT_W'(BURST))) || (sel_empty && !rd_go)) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRN_W'(PIPE_LAT)) begin
                    state_d     = S_IDLE;
                    last_d      = sel_q;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRN_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        complete_d  = (state_d == S_DRAIN) && (drain_cnt_d == DRN_W'(PIPE_LAT));
        sym_valid_d = rd_go;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge dclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
            drain_cnt_q <= '0;
            complete_q  <= 1'b0;
            sym_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            complete_q  <= complete_d;
            sym_valid_q <= sym_valid_d;
        end
    end

    assign bus.rd_en0    = rd_go && !sel_q;
    assign bus.rd_en1    = rd_go && sel_q;
    assign bus.available = (state_q == S_IDLE) && grant_ok && !reset;
    assign bus.sel       = sel_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.complete  = complete_q;
    assign bus.burst_cnt = burst_cnt_q;
    assign bus.state     = 2'(state_q);

endmodule

// File: tb/tb_qam_demapper_scheduler.sv
// Bench for qam_demapper_scheduler: directed scenarios followed by randomized traffic,
// all checked every cycle against a phase/countdown reference model with FIFO occupancy models.
module tb_qam_demapper_scheduler;
    localparam int unsigned BURST    = 8;
    localparam int unsigned PIPE_LAT = 3;
    localparam int unsigned CNT_W    = 4;

    logic dclk;
    logic reset;

    qam_demapper_scheduler_if #(.CNT_W(CNT_W)) bus ();

    qam_demapper_scheduler #(
        .BURST    (BURST),
        .PIPE_LAT (PIPE_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .dclk  (dclk),
        .reset (reset),
        .bus   (bus)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    int total = 0;
    int bad   = 0;

    // stimulus knobs and FIFO occupancy
    int cnt0 = 0, cnt1 = 0;
    bit k_en = 0, k_wf = 0, k_rst = 1, f_e0 = 0;

    // reference model: phase 0 idle, 1 grant, 2 burst, 3 drain
    int m_phase = 0, m_ch = 0, m_last = 1, m_cnt = 0, m_drain_left = 0;
    bit m_cmp = 0, m_sv = 0;

    // observed per-burst records taken at each complete pulse
    int comp_sel[$];
    int comp_cnt[$];
    int comp_rd[$];
    int rd_pulses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_log();
        comp_sel.delete();
        comp_cnt.delete();
        comp_rd.delete();
    endtask

    // One clock cycle: apply inputs, check at negedge, advance model and FIFOs.
    task automatic tick();
        bit e0, e1, sel_e, ex_avail, ex_rd, ex_rd0, ex_rd1;
        e0 = (cnt0 == 0) || f_e0;
        e1 = (cnt1 == 0);
        bus.rdempty0 = e0;
        bus.rdempty1 = e1;
        bus.wfull    = k_wf;
        bus.enable   = k_en;
        reset        = k_rst;
        @(negedge dclk);
        sel_e    = (m_ch == 1) ? e1 : e0;
        ex_avail = !k_rst && (m_phase == 0) && k_en && !k_wf && (!e0 || !e1);
        ex_rd    = !k_rst && (m_phase == 2) && !sel_e && !k_wf && (m_cnt < BURST);
        ex_rd0   = ex_rd && (m_ch == 0);
        ex_rd1   = ex_rd && (m_ch == 1);

        check("state",     32'(bus.state),     32'(m_phase));
        check("sel",       32'(bus.sel),       32'(m_ch));
        check("burst_cnt", 32'(bus.burst_cnt), 32'(m_cnt));
        check("rd_en0",    32'(bus.rd_en0),    32'(ex_rd0));
        check("rd_en1",    32'(bus.rd_en1),    32'(ex_rd1));
        check("available", 32'(bus.available), 32'(ex_avail));
        check("sym_valid", 32'(bus.sym_valid), 32'(m_sv));
        check("complete",  32'(bus.complete),  32'(m_cmp));
        check("rd_excl",   32'(bus.rd_en0 && bus.rd_en1), 32'(0));

        if (bus.rd_en0 || bus.rd_en1) rd_pulses++;
        if (bus.complete === 1'b1) begin
            comp_sel.push_back(int'(bus.sel));
            comp_cnt.push_back(int'(bus.burst_cnt));
            comp_rd.push_back(rd_pulses);
            rd_pulses = 0;
        end
        if (k_rst) rd_pulses = 0;

        if (k_rst) begin
            m_phase = 0; m_ch = 0; m_last = 1; m_cnt = 0; m_drain_left = 0;
            m_cmp = 0; m_sv = 0;
        end else begin
            m_sv = ex_rd;
            case (m_phase)
                0: if (ex_avail) begin
                    if (!e0 && !e1) m_ch = (m_last == 0) ? 1 : 0;
                    else            m_ch = e0 ? 1 : 0;
                    m_cnt   = 0;
                    m_phase = 1;
                end
                1: m_phase = 2;
                2: begin
                    if (ex_rd) m_cnt++;
                    if (m_cnt == BURST || (sel_e && !ex_rd)) begin
                        m_phase      = 3;
                        m_drain_left = PIPE_LAT + 1;
                    end
                end
                default: begin
                    m_drain_left--;
                    if (m_drain_left == 0) begin
                        m_phase = 0;
                        m_last  = m_ch;
                    end
                end
            endcase
            m_cmp = (m_phase == 3) && (m_drain_left == 1);
        end

        @(posedge dclk);
        #1;
        if (ex_rd0 && cnt0 > 0) cnt0--;
        if (ex_rd1 && cnt1 > 0) cnt1--;
    endtask

    task automatic wait_comp(input int n, input int bound);
        for (int i = 0; i < bound && comp_cnt.size() < n; i++) tick();
        check("n_complete", 32'(comp_cnt.size()), 32'(n));
    endtask

    initial begin
        bus.enable = 1'b0; bus.rdempty0 = 1'b1; bus.rdempty1 = 1'b1; bus.wfull = 1'b0;
        reset = 1'b1;

        // reset, then ch0 holds 20 symbols, ch1 empty
        k_rst = 1; k_en = 1; cnt0 = 20; cnt1 = 0;
        tick(); tick();
        k_rst = 0;
        check("rst_state",     32'(bus.state),     32'(0));
        check("rst_sel",       32'(bus.sel),       32'(0));
        check("rst_burst_cnt", 32'(bus.burst_cnt), 32'(0));
        check("rst_complete",  32'(bus.complete),  32'(0));
        check("rst_sym_valid", 32'(bus.sym_valid), 32'(0));
        clear_log();
        wait_comp(3, 200);
        check("s1_cnt0", 32'(comp_cnt[0]), 32'(8));
        check("s1_cnt1", 32'(comp_cnt[1]), 32'(8));
        check("s1_cnt2", 32'(comp_cnt[2]), 32'(4));
        check("s1_sel2", 32'(comp_sel[2]), 32'(0));
        check("s1_rd2",  32'(comp_rd[2]),  32'(4));

        // both channels busy: strict alternation from reset
        k_rst = 1; cnt0 = 200; cnt1 = 200;
        tick();
        k_rst = 0;
        clear_log();
        wait_comp(4, 200);
        for (int i = 0; i < 4; i++) begin
            check("s2_sel", 32'(comp_sel[i]), 32'(i % 2));
            check("s2_cnt", 32'(comp_cnt[i]), 32'(8));
            check("s2_rd",  32'(comp_rd[i]),  32'(8));
        end

        // wfull stall after 3 reads
        clear_log();
        for (int i = 0; i < 100 && !(m_phase == 2 && m_cnt == 3); i++) tick();
        k_wf = 1;
        repeat (5) tick();
        k_wf = 0;
        check("s3_hold_cnt",   32'(bus.burst_cnt), 32'(3));
        check("s3_hold_state", 32'(bus.state),     32'(2));
        check("s3_hold_rd",    32'(rd_pulses),     32'(3));
        wait_comp(1, 100);
        check("s3_cnt", 32'(comp_cnt[0]), 32'(8));

        // enable dropped during the 2nd read
        clear_log();
        for (int i = 0; i < 100 && !(m_phase == 2 && m_cnt == 1); i++) tick();
        k_en = 0;
        wait_comp(1, 100);
        check("s4_cnt", 32'(comp_cnt[0]), 32'(8));
        repeat (10) tick();
        check("s4_state", 32'(bus.state),     32'(0));
        check("s4_avail", 32'(bus.available), 32'(0));

        // zero-length burst: ch0 empties in the grant cycle
        k_en = 1; k_rst = 1;
        tick();
        k_rst = 0;
        clear_log();
        for (int i = 0; i < 20 && m_phase != 1; i++) tick();
        f_e0 = 1;
        wait_comp(1, 50);
        f_e0 = 0;
        check("s5_cnt", 32'(comp_cnt[0]), 32'(0));
        check("s5_sel", 32'(comp_sel[0]), 32'(0));
        check("s5_rd",  32'(comp_rd[0]),  32'(0));
        wait_comp(2, 50);
        check("s5_next_sel", 32'(comp_sel[1]), 32'(1));

        // reset while draining a ch1 burst
        for (int i = 0; i < 100 && !(m_phase == 3 && m_ch == 1); i++) tick();
        check("s6_in_drain", 32'(bus.state), 32'(3));
        k_rst = 1;
        tick();
        k_rst = 0;
        check("s6_state",     32'(bus.state),     32'(0));
        check("s6_sel",       32'(bus.sel),       32'(0));
        check("s6_complete",  32'(bus.complete),  32'(0));
        check("s6_sym_valid", 32'(bus.sym_valid), 32'(0));
        clear_log();
        wait_comp(1, 50);
        check("s6_tie_sel", 32'(comp_sel[0]), 32'(0));

        // randomized traffic, backpressure, enable drops and occasional reset
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 1500; i++) begin
            if (cnt0 == 0 && $urandom_range(0, 3) == 0) cnt0 = int'($urandom_range(0, 12));
            if (cnt1 == 0 && $urandom_range(0, 3) == 0) cnt1 = int'($urandom_range(0, 12));
            k_wf  = ($urandom_range(0, 6) == 0);
            k_en  = ($urandom_range(0, 9) != 0);
            k_rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        k_rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
